// File: rtl/penalty_round_ctl.sv
// penalty_round_ctl: sequences one penalty round.
// A click arms the round and a target zone is latched. The aim and flight
// timers then run, the glove position is judged against the target, and the
// round ends with is_scored plus a single-cycle round_done pulse.
module penalty_round_ctl #(
  parameter int GOAL_X0       = 112,
  parameter int GOAL_Y0       = 160,
  parameter int ZONE_W        = 256,
  parameter int ZONE_H        = 160,
  parameter int SAVE_RADIUS   = 64,
  parameter int AIM_CYCLES    = 4,
  parameter int FLIGHT_CYCLES = 16,
  parameter int RESULT_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_round_enable,
  input  logic        i_left_clicked,
  input  logic [11:0] i_xpos,
  input  logic [11:0] i_ypos,
  input  logic        i_ext_zone_valid,
  input  logic [2:0]  i_ext_zone,
  output logic [11:0] o_shot_xpos,
  output logic [11:0] o_shot_ypos,
  output logic        o_ball_active,
  output logic [7:0]  o_flight_cnt,
  output logic        o_is_scored,
  output logic        o_round_done,
  output logic        o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_AIM,
    S_FLIGHT,
    S_CHECK,
    S_RESULT
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_next;
  logic [15:0] r_lfsr;
  logic        r_click_d;
  logic [11:0] r_shot_x;
  logic [11:0] r_shot_y;
  logic        r_is_scored;

  logic        w_edge;
  logic        w_lfsr_fb;
  logic [2:0]  w_raw;
  logic [2:0]  w_lfsr_zone;
  logic [2:0]  w_ext_zone;
  logic [2:0]  w_zone;
  logic [1:0]  w_col;
  logic        w_row;
  logic [11:0] w_shot_x;
  logic [11:0] w_shot_y;
  logic signed [12:0] w_dx;
  logic signed [12:0] w_dy;
  logic [12:0] w_adx;
  logic [12:0] w_ady;
  logic        w_saved;
  logic        w_latch;
  logic        w_score_we;
  logic        w_done;

  // The click edge is a rising level; the LFSR zone folds raw values 6 and 7 onto 0 and 1.
  assign w_edge      = i_left_clicked & ~r_click_d;
  assign w_lfsr_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_raw       = r_lfsr[2:0];
  assign w_lfsr_zone = (w_raw >= 3'd6) ? (w_raw - 3'd6) : w_raw;
  assign w_ext_zone  = (i_ext_zone > 3'd5) ? 3'd5 : i_ext_zone;
  assign w_zone      = i_ext_zone_valid ? w_ext_zone : w_lfsr_zone;

  // The zone grid is three columns by two rows; the target is the centre of the chosen cell.
  assign w_col    = (w_zone >= 3'd3) ? 2'(w_zone - 3'd3) : w_zone[1:0];
  assign w_row    = (w_zone >= 3'd3);
  assign w_shot_x = 12'(GOAL_X0 + ZONE_W / 2) + 12'(w_col) * 12'(ZONE_W);
  assign w_shot_y = 12'(GOAL_Y0 + ZONE_H / 2) + (w_row ? 12'(ZONE_H) : 12'd0);

  // Glove-to-target distance uses 13-bit signed differences so that the magnitudes cannot wrap.
  assign w_dx    = $signed({1'b0, i_xpos}) - $signed({1'b0, r_shot_x});
  assign w_dy    = $signed({1'b0, i_ypos}) - $signed({1'b0, r_shot_y});
  assign w_adx   = w_dx[12] ? 13'(-w_dx) : 13'(w_dx);
  assign w_ady   = w_dy[12] ? 13'(-w_dy) : 13'(w_dy);
  assign w_saved = (w_adx <= 13'(SAVE_RADIUS)) && (w_ady <= 13'(SAVE_RADIUS));

  // Next-state and strobe logic; dropping round_enable abandons the round silently.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_latch      = 1'b0;
    w_score_we   = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_round_enable && w_edge) begin
          w_latch      = 1'b1;
          w_next_state = S_AIM;
          w_cnt_next   = 32'd0;
        end
      end
      S_AIM: begin
        if (r_cnt == 32'(AIM_CYCLES - 1)) begin
          w_next_state = S_FLIGHT;
          w_cnt_next   = 32'd0;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      S_FLIGHT: begin
        if (r_cnt == 32'(FLIGHT_CYCLES - 1)) begin
          w_next_state = S_CHECK;
          w_cnt_next   = 32'd0;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      S_CHECK: begin
        w_score_we   = 1'b1;
        w_next_state = S_RESULT;
        w_cnt_next   = 32'd0;
      end
      S_RESULT: begin
        if (r_cnt == 32'(RESULT_CYCLES - 1)) begin
          w_done       = 1'b1;
          w_next_state = S_IDLE;
          w_cnt_next   = 32'd0;
        end else begin
          w_cnt_next = r_cnt + 32'd1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = 32'd0;
      end
    endcase
    if (!i_round_enable && (r_state != S_IDLE)) begin
      w_next_state = S_IDLE;
      w_cnt_next   = 32'd0;
      w_score_we   = 1'b0;
      w_done       = 1'b0;
    end
  end

  // State, counter, LFSR, click history, latched target and result registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 32'd0;
      r_lfsr      <= 16'hACE1;
      r_click_d   <= 1'b0;
      r_shot_x    <= 12'd0;
      r_shot_y    <= 12'd0;
      r_is_scored <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_cnt_next;
      r_lfsr    <= {r_lfsr[14:0], w_lfsr_fb};
      r_click_d <= i_left_clicked;
      if (w_latch) begin
        r_shot_x <= w_shot_x;
        r_shot_y <= w_shot_y;
      end
      if (w_score_we) begin
        r_is_scored <= ~w_saved;
      end
    end
  end

  assign o_shot_xpos   = r_shot_x;
  assign o_shot_ypos   = r_shot_y;
  assign o_ball_active = (r_state == S_FLIGHT);
  assign o_flight_cnt  = (r_state == S_FLIGHT) ?
                         ((r_cnt > 32'd255) ? 8'hFF : r_cnt[7:0]) : 8'd0;
  assign o_is_scored   = r_is_scored;
  assign o_round_done  = w_done;
  assign o_busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_penalty_round_ctl.sv
// Testbench for penalty_round_ctl: directed rounds plus randomized rounds,
// checked by a scoreboard that is filled on each click and drained on round_done.
module tb_penalty_round_ctl;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        roundEnable = 1'b0;
  logic        leftClicked = 1'b0;
  logic [11:0] xpos = 12'd0;
  logic [11:0] ypos = 12'd0;
  logic        extZoneValid = 1'b0;
  logic [2:0]  extZone = 3'd0;
  logic [11:0] shotX;
  logic [11:0] shotY;
  logic        ballActive;
  logic [7:0]  flightCnt;
  logic        isScored;
  logic        roundDone;
  logic        busy;

  typedef struct {
    int x;
    int y;
    int scored;
    int doneCyc;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lastScored = 0;
  logic [15:0] refLfsr;

  penalty_round_ctl dut (
    .i_clk            (clk),
    .i_rst            (rstN),
    .i_round_enable   (roundEnable),
    .i_left_clicked   (leftClicked),
    .i_xpos           (xpos),
    .i_ypos           (ypos),
    .i_ext_zone_valid (extZoneValid),
    .i_ext_zone       (extZone),
    .o_shot_xpos      (shotX),
    .o_shot_ypos      (shotY),
    .o_ball_active    (ballActive),
    .o_flight_cnt     (flightCnt),
    .o_is_scored      (isScored),
    .o_round_done     (roundDone),
    .o_busy           (busy)
  );

  always #5 clk = ~clk;

  // Cycle index: incremented at every rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference pseudo-random sequence: 16-bit Fibonacci register, taps 16,14,13,11.
  always @(posedge clk or negedge rstN) begin
    if (!rstN) refLfsr <= 16'hACE1;
    else       refLfsr <= {refLfsr[14:0], refLfsr[15] ^ refLfsr[13] ^ refLfsr[12] ^ refLfsr[10]};
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int absInt(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Monitor: every round_done must match the oldest outstanding round.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rstN && roundDone) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected round_done", int'(roundDone), 0);
      end else begin
        e = expQ.pop_front();
        checkOutput("round_done cycle", cyc, e.doneCyc);
        checkOutput("shot_xpos at done", int'(shotX), e.x);
        checkOutput("shot_ypos at done", int'(shotY), e.y);
        checkOutput("is_scored at done", int'(isScored), e.scored);
      end
    end
  end

  // Issue one click in the cycle after the next rising edge and, if a round should follow, queue its outcome.
  task automatic applyStimulus(input bit useExt, input logic [2:0] zone, input int gx, input int gy,
                               input bit expectDone, output int edgeCyc, output int ex, output int ey);
    int z;
    int raw;
    int scored;
    @(posedge clk); #1;
    xpos         = 12'(gx);
    ypos         = 12'(gy);
    extZoneValid = useExt;
    extZone      = zone;
    leftClicked  = 1'b1;
    edgeCyc      = cyc;
    raw          = int'(refLfsr[2:0]);
    if (useExt) z = (int'(zone) > 5) ? 5 : int'(zone);
    else        z = (raw >= 6) ? raw - 6 : raw;
    ex     = 240 + (z % 3) * 256;
    ey     = 240 + (z / 3) * 160;
    scored = (absInt(gx - ex) > 64 || absInt(gy - ey) > 64) ? 1 : 0;
    if (expectDone) begin
      expQ.push_back('{ex, ey, scored, edgeCyc + 29});
      lastScored = scored;
    end
    @(posedge clk); #1;
    leftClicked = 1'b0;
  endtask

  // Wait until every queued round has completed, bounded by a cycle budget.
  task automatic waitIdle(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (expQ.size() != 0) begin
      checkOutput("round completion timeout", expQ.size(), 0);
      expQ.delete();
    end
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int t, ex, ey, legal, gx, gy, c;
    $display("[TB] starting penalty_round_ctl bench");

    // Reset state.
    rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset shot_xpos", int'(shotX), 0);
    checkOutput("reset shot_ypos", int'(shotY), 0);
    checkOutput("reset ball_active", int'(ballActive), 0);
    checkOutput("reset flight_cnt", int'(flightCnt), 0);
    checkOutput("reset is_scored", int'(isScored), 0);
    checkOutput("reset round_done", int'(roundDone), 0);
    checkOutput("reset busy", int'(busy), 0);
    @(negedge clk);
    rstN        = 1'b1;
    roundEnable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle busy after reset", int'(busy), 0);

    // Save in zone 4, with a cycle-by-cycle timing profile.
    applyStimulus(1'b1, 3'd4, 500, 410, 1'b1, t, ex, ey);
    for (int k = 1; k <= 30; k++) begin
      if (k == 1) begin
        checkOutput("zone4 shot_xpos", int'(shotX), 496);
        checkOutput("zone4 shot_ypos", int'(shotY), 400);
      end
      checkOutput("zone4 busy", int'(busy), (k <= 29) ? 1 : 0);
      checkOutput("zone4 ball_active", int'(ballActive), (k >= 5 && k <= 20) ? 1 : 0);
      checkOutput("zone4 flight_cnt", int'(flightCnt), (k >= 5 && k <= 20) ? k - 5 : 0);
      @(posedge clk); #1;
    end
    waitIdle(10);

    // Goal in zone 0.
    applyStimulus(1'b1, 3'd0, 400, 240, 1'b1, t, ex, ey);
    waitIdle(60);

    // Boundary in zone 2: exactly on the radius is a save, one pixel beyond is a goal.
    // The second click lands in the first idle cycle after round_done.
    applyStimulus(1'b1, 3'd2, 816, 240, 1'b1, t, ex, ey);
    waitIdle(60);
    applyStimulus(1'b1, 3'd2, 817, 240, 1'b1, t, ex, ey);
    waitIdle(60);

    // External zones 6 and 7 fold onto zone 5.
    applyStimulus(1'b1, 3'd6, 752, 400, 1'b1, t, ex, ey);
    waitIdle(60);
    applyStimulus(1'b1, 3'd7, 700, 300, 1'b1, t, ex, ey);
    waitIdle(60);

    // Abort during AIM: no round_done, result unchanged.
    applyStimulus(1'b1, 3'd1, 0, 0, 1'b0, t, ex, ey);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("abort busy in aim", int'(busy), 1);
    roundEnable = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort busy after drop", int'(busy), 0);
    roundEnable = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("abort still idle", int'(busy), 0);
    checkOutput("abort is_scored held", int'(isScored), lastScored);

    // Second click during FLIGHT is ignored.
    applyStimulus(1'b1, 3'd3, 240, 400, 1'b1, t, ex, ey);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("reclick in flight", int'(ballActive), 1);
    leftClicked = 1'b1;
    @(posedge clk); #1;
    leftClicked = 1'b0;
    waitIdle(60);
    repeat (40) @(posedge clk);
    #1;
    checkOutput("reclick no second round", int'(busy), 0);

    // LFSR-chosen targets over several rounds at varying phases.
    for (int i = 0; i < 6; i++) begin
      c  = int'($urandom_range(0, 5));
      gx = 240 + (c % 3) * 256 + int'($urandom_range(0, 160)) - 80;
      gy = 240 + (c / 3) * 160 + int'($urandom_range(0, 160)) - 80;
      repeat ($urandom_range(0, 7)) @(posedge clk);
      applyStimulus(1'b0, 3'd0, gx, gy, 1'b1, t, ex, ey);
      legal = ((shotX == 12'd240 || shotX == 12'd496 || shotX == 12'd752) &&
               (shotY == 12'd240 || shotY == 12'd400)) ? 1 : 0;
      checkOutput("lfsr shot legal", legal, 1);
      checkOutput("lfsr shot_xpos", int'(shotX), ex);
      checkOutput("lfsr shot_ypos", int'(shotY), ey);
      waitIdle(60);
    end

    // Randomized external zones and glove positions.
    for (int i = 0; i < 6; i++) begin
      c  = int'($urandom_range(0, 5));
      gx = 240 + (c % 3) * 256 + int'($urandom_range(0, 160)) - 80;
      gy = 240 + (c / 3) * 160 + int'($urandom_range(0, 160)) - 80;
      applyStimulus(1'b1, 3'($urandom_range(0, 7)), gx, gy, 1'b1, t, ex, ey);
      waitIdle(60);
    end

    // Asynchronous reset in the middle of FLIGHT.
    applyStimulus(1'b1, 3'd5, 752, 400, 1'b1, t, ex, ey);
    repeat (8) @(posedge clk);
    #1;
    checkOutput("mid-flight ball_active", int'(ballActive), 1);
    #2;
    rstN = 1'b0;
    #1;
    expQ.delete();
    checkOutput("async reset ball_active", int'(ballActive), 0);
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset flight_cnt", int'(flightCnt), 0);
    checkOutput("async reset shot_xpos", int'(shotX), 0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    checkOutput("idle after reset release", int'(busy), 0);

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
